// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter and sequencer that shares one
// add-and-extend datapath among NUM_REQ operand-pair requesters.
// A grant is taken in IDLE, the operands are registered in CALC, and the
// tagged 32-bit result is held in RESP until the consumer accepts it.
// Only one transaction is in flight at any time.

// Shared datapath: the upper half is constant, the lower half is the
// 16-bit sum with the carry discarded.
module multiplier (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] c
);

  logic [15:0] sum_s;

  assign sum_s = a + b;
  assign c     = {16'hFFFF, sum_s};

endmodule

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy,
  output logic [15:0]             txn_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Registered state and its next-state companions.
  state_e            state_q,      state_d;
  logic [15:0]       op_a_q,       op_a_d;
  logic [15:0]       op_b_q,       op_b_d;
  logic [IDX_W-1:0]  id_q,         id_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic              rsp_valid_q,  rsp_valid_d;
  logic [31:0]       rsp_data_q,   rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q,     rsp_id_d;
  logic [15:0]       txn_count_q,  txn_count_d;
  logic              busy_q,       busy_d;

  // Arbitration and datapath signals.
  logic [15:0]       req_a_arr_s [NUM_REQ];
  logic [15:0]       req_b_arr_s [NUM_REQ];
  logic              grant_found_s;
  logic [IDX_W-1:0]  grant_idx_s;
  logic [IDX_W-1:0]  cand_idx_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [31:0]       dp_c_s;

  // Split the packed operand buses into per-requester lanes.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_a_arr_s[gi] = req_a[16*gi +: 16];
    assign req_b_arr_s[gi] = req_b[16*gi +: 16];
  end

  // The single shared datapath, fed only from the registered operands.
  multiplier u_datapath (
    .a (op_a_q),
    .b (op_b_q),
    .c (dp_c_s)
  );

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_idx_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx_s = IDX_W'((32'(last_grant_q) + 32'(k)) % 32'(NUM_REQ));
      if (!grant_found_s && req_valid[cand_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state and handshake logic for the IDLE/CALC/RESP sequence.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    txn_count_d  = txn_count_q;
    req_ready_s  = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
          op_a_d       = req_a_arr_s[grant_idx_s];
          op_b_d       = req_b_arr_s[grant_idx_s];
          id_d         = grant_idx_s;
          last_grant_d = grant_idx_s;
          state_d      = ST_CALC;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_CALC: begin
        rsp_data_d  = dp_c_s;
        rsp_id_d    = ID_W'(id_q);
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, operand and response registers; reset abandons any transaction.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      op_a_q       <= 16'h0000;
      op_b_q       <= 16'h0000;
      id_q         <= '0;
      last_grant_q <= LAST_IDX;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'h0000_0000;
      rsp_id_q     <= '0;
      txn_count_q  <= 16'h0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      txn_count_q  <= txn_count_d;
      busy_q       <= busy_d;
    end
  end

  // req_ready is a same-cycle grant, held off entirely while in reset.
  assign req_ready = req_ready_s & {NUM_REQ{aresetn}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a cycle-level transaction model checked on every
// falling edge, directed scenarios with literal expectations, and a
// randomized traffic phase.
module tb_adder_arbiter;

  localparam int N = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          busy;
  logic [15:0]   txn_count;

  int n_checks = 0;
  int n_errors = 0;
  int preload_cnt = 0;

  adder_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .txn_count (txn_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // ---------------- behavioural model + compare process ----------------
  bit          m_inflight, m_calc, m_rv;
  logic [31:0] m_data;
  logic [1:0]  m_id;
  logic [15:0] m_txn, m_sum;
  int          m_last, m_grant, preload_seen;
  logic [3:0]  m_exp_rdy;

  initial begin
    m_inflight = 0; m_calc = 0; m_rv = 0; m_data = 32'h0; m_id = 2'd0;
    m_txn = 16'h0; m_sum = 16'h0; m_last = N - 1; preload_seen = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_inflight = 0; m_calc = 0; m_rv = 0; m_txn = 16'h0; m_last = N - 1;
        chk("m_rst_ready", {28'h0, req_ready}, 32'h0);
        chk("m_rst_valid", {31'h0, rsp_valid}, 32'h0);
        chk("m_rst_busy",  {31'h0, busy}, 32'h0);
        chk("m_rst_txn",   {16'h0, txn_count}, 32'h0);
        chk("m_rst_data",  rsp_data, 32'h0);
        chk("m_rst_id",    {30'h0, rsp_id}, 32'h0);
      end else begin
        if (preload_cnt != preload_seen) begin
          preload_seen = preload_cnt;
          m_txn = 16'hFFFE;
        end
        m_grant = -1;
        if (!m_inflight) begin
          for (int k = 1; k <= N; k++) begin
            if (m_grant < 0 && req_valid[(m_last + k) % N]) m_grant = (m_last + k) % N;
          end
        end
        m_exp_rdy = 4'b0000;
        if (m_grant >= 0) m_exp_rdy[m_grant] = 1'b1;
        chk("m_req_ready", {28'h0, req_ready}, {28'h0, m_exp_rdy});
        chk("m_rsp_valid", {31'h0, rsp_valid}, {31'h0, m_rv});
        chk("m_busy",      {31'h0, busy}, {31'h0, m_inflight});
        chk("m_txn_count", {16'h0, txn_count}, {16'h0, m_txn});
        if (m_rv) begin
          chk("m_rsp_data", rsp_data, m_data);
          chk("m_rsp_id",   {30'h0, rsp_id}, {30'h0, m_id});
        end
        if (m_grant >= 0) begin
          m_inflight = 1; m_calc = 1;
          m_sum  = req_a[m_grant*16 +: 16] + req_b[m_grant*16 +: 16];
          m_id   = 2'(m_grant);
          m_last = m_grant;
        end else if (m_calc) begin
          m_calc = 0; m_rv = 1; m_data = {16'hFFFF, m_sum};
        end else if (m_rv && rsp_ready) begin
          m_rv = 0; m_inflight = 0; m_txn = m_txn + 16'd1;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Present one request, wait for grant and response, optionally complete it.
  task automatic send(input int idx, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input string nm, input bit do_hs,
                      output int acc_wait, output int rsp_wait);
    bit got;
    req_a[idx*16 +: 16] = a;
    req_b[idx*16 +: 16] = b;
    req_valid[idx] = 1'b1;
    got = 0; acc_wait = -1; rsp_wait = -1;
    for (int k = 0; k < 12 && !got; k++) begin
      #1;
      if (req_ready[idx]) begin got = 1; acc_wait = k; end
      tick();
    end
    req_valid[idx] = 1'b0;
    chk({nm, "_granted"}, {31'h0, got}, 32'h1);
    got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      #1;
      if (rsp_valid) begin
        got = 1; rsp_wait = k;
        chk({nm, "_data"}, rsp_data, exp);
        chk({nm, "_id"}, {30'h0, rsp_id}, 32'(idx));
      end else begin
        tick();
      end
    end
    chk({nm, "_rsp_seen"}, {31'h0, got}, 32'h1);
    if (do_hs) tick();
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    tick();
    tick();
    #2 aresetn = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  int aw, rw, ng;
  int order[5];
  int when[5];
  logic [3:0] acc;

  initial begin
    aresetn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    tick(); tick();
    #1;
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_req_ready", {28'h0, req_ready}, 32'h0);
    chk("reset_busy",      {31'h0, busy}, 32'h0);
    chk("reset_txn",       {16'h0, txn_count}, 32'h0);
    #1 aresetn = 1'b1;
    tick();

    // Single request from requester 2.
    send(2, 16'h1234, 16'h0001, 32'hFFFF1235, "single", 1'b1, aw, rw);
    chk("single_accept_same_cycle", 32'(aw), 32'd0);
    chk("single_rsp_latency", 32'(rw), 32'd1);
    #1;
    chk("single_txn", {16'h0, txn_count}, 32'h1);
    chk("single_idle_busy", {31'h0, busy}, 32'h0);
    tick();

    // Modulo-2^16 sums.
    send(0, 16'hFFFF, 16'h0001, 32'hFFFF0000, "wrap1", 1'b1, aw, rw);
    send(1, 16'h8000, 16'h8000, 32'hFFFF0000, "wrap2", 1'b1, aw, rw);

    // Round-robin with all requesters held valid from reset.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = 16'(i);
      req_b[i*16 +: 16] = 16'h0100;
    end
    req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      chk("rr_onehot", {31'h0, ($countones(req_ready) <= 1)}, 32'h1);
      if (req_ready != 4'b0000 && ng < 5) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) order[ng] = i;
        when[ng] = c;
        ng++;
      end
      if (rsp_valid) chk("rr_data", rsp_data, 32'hFFFF0100 + {30'h0, rsp_id});
      tick();
    end
    req_valid = 4'b0000;
    chk("rr_grant_count", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(order[i]), 32'(i % N));
    for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(when[i] - when[i-1]), 32'd3);
    repeat (4) tick();

    // Backpressure with a competing request arriving during RESP.
    rsp_ready = 1'b0;
    send(1, 16'h0010, 16'h0020, 32'hFFFF0030, "bp", 1'b0, aw, rw);
    req_a[15:0] = 16'h0005; req_b[15:0] = 16'h0006; req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_data",  rsp_data, 32'hFFFF0030);
      chk("bp_id",    {30'h0, rsp_id}, 32'h1);
      chk("bp_ready", {28'h0, req_ready}, 32'h0);
      chk("bp_busy",  {31'h0, busy}, 32'h1);
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_done_valid", {31'h0, rsp_valid}, 32'h0);
    chk("bp_done_busy",  {31'h0, busy}, 32'h0);
    chk("bp_next_grant", {28'h0, req_ready}, 32'h1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    #1;
    chk("bp_next_data", rsp_data, 32'hFFFF000B);
    chk("bp_next_id",   {30'h0, rsp_id}, 32'h0);
    tick();

    // Reset while the response is pending.
    rsp_ready = 1'b0;
    send(3, 16'h0100, 16'h0200, 32'hFFFF0300, "rr3", 1'b0, aw, rw);
    #1 aresetn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_txn",   {16'h0, txn_count}, 32'h0);
    chk("mid_rst_ready", {28'h0, req_ready}, 32'h0);
    tick(); tick();
    #2 aresetn = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_first_grant", {28'h0, req_ready}, 32'h1);
    tick();
    req_valid = 4'b0000;
    repeat (3) tick();

    // Counter wrap via preload.
    force dut.txn_count_q = 16'hFFFE;
    preload_cnt++;
    #1;
    release dut.txn_count_q;
    tick();
    send(0, 16'h0001, 16'h0001, 32'hFFFF0002, "cw1", 1'b1, aw, rw);
    #1;
    chk("cw_ffff", {16'h0, txn_count}, 32'h0000FFFF);
    tick();
    send(2, 16'h0002, 16'h0003, 32'hFFFF0005, "cw2", 1'b1, aw, rw);
    #1;
    chk("cw_wrap", {16'h0, txn_count}, 32'h00000000);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      #1;
      acc = req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(0, 99) < 40) begin
            req_a[i*16 +: 16] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            req_b[i*16 +: 16] = 16'($urandom);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 99) < 8) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares the single 16-bit add-and-extend datapath (`Multiplier`: c = {16'hFFFF, a+b}) among NUM_REQ requesters. Each requester presents an operand pair under valid/ready. The arbiter grants one requester, registers its operands into the shared datapath, and returns the registered 32-bit result tagged with the requester ID under valid/ready. It sits between the custom-IP register/stream front ends and the datapath instance, which it instantiates internally.

## Interface
- NUM_REQ, 4, number of requesters; legal values 2..8.
- ID_W, 2, width of rsp_id; must be ≥ clog2(NUM_REQ).
- aclk  in  1  sole clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  16*NUM_REQ  operand a; requester i on bits [16i+15:16i].
- req_b  in  16*NUM_REQ  operand b; same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer accept.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  32  registered datapath result.
- busy  out  1  high in any state other than IDLE.
- txn_count  out  16  completed-response counter; wraps 0xFFFF→0x0000.

## Operation
- FSM states:
  - IDLE
    - Stays in IDLE while no req_valid bit is set.
    - Otherwise selects a grant index g round-robin, searching from last_grant+1 upward modulo NUM_REQ.
    - req_ready[g] is driven combinationally high in the same cycle.
    - On that edge: operand registers ← req_a[g], req_b[g]; id_reg ← g; last_grant ← g; next state CALC.
  - CALC
    - Operand registers drive the datapath.
    - On the edge: rsp_data ← datapath c; rsp_id ← id_reg; rsp_valid ← 1; next state RESP.
  - RESP
    - Holds rsp_valid, rsp_data and rsp_id stable until rsp_valid && rsp_ready.
    - On that edge: rsp_valid ← 0; txn_count ← txn_count+1; next state IDLE.
- req_ready is 0 in CALC and RESP. No new request is accepted until the response handshake completes, so at most one transaction is in flight.
- Arithmetic:
  - Sum is 16-bit modulo 2^16; the carry is discarded.
  - rsp_data[31:16] is always 16'hFFFF.
  - rsp_data[15:0] = (a+b) mod 65536.
- Requester-side rules:
  - A requester must hold req_a/req_b stable while req_valid is high and not yet accepted.
  - A requester may drop req_valid without a handshake; it then simply loses arbitration.
- Fairness: a requester with valid held high is granted within NUM_REQ transactions.

## Timing
- Reset values (aresetn low):
  - state IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
  - rsp_valid 0, rsp_data 0, rsp_id 0, txn_count 0, busy 0.
  - req_ready forced to all-zero while aresetn is low.
- Reset during CALC or RESP: the transaction is abandoned and rsp_valid drops asynchronously. No response is ever delivered for it, and txn_count is not incremented.
- Latency: request handshake at edge T; rsp_valid high after edge T+1; earliest response handshake at edge T+2; next request accepted at edge T+3.
- Peak throughput: one transaction per 3 cycles.
- Each extra cycle rsp_ready stays low adds one cycle of latency.
- Simultaneous events:
  - A request arriving in RESP waits; it is arbitrated in the IDLE cycle after the response handshake.
  - A request valid asserted in the same cycle as a response handshake is evaluated in the next IDLE cycle.
- busy is registered state decode: high from the edge after the request handshake through the response-handshake edge.

## Test plan
- Single request: reset; requester 2 sends a=0x1234, b=0x0001; rsp_ready=1. Expect req_ready[2] in the same cycle; rsp_valid two edges later with rsp_data=0xFFFF1235, rsp_id=2, txn_count=1.
- Wrap arithmetic: a=0xFFFF, b=0x0001 → rsp_data=0xFFFF0000. Then a=0x8000, b=0x8000 → rsp_data=0xFFFF0000.
- Round-robin: all four requesters hold valid from reset with a=i, b=0x0100. Expect grant order 0,1,2,3,0; rsp_data=0xFFFF0100+i; no req_ready overlap; accepts exactly 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Expect rsp_data/rsp_id stable, req_ready all 0, busy=1. Handshake completes on the first rsp_ready=1 edge.
- Reset mid-RESP: assert aresetn low while rsp_valid=1. Expect rsp_valid=0 immediately, txn_count=0, and after release requester 0 granted first.
- Counter wrap: force 65536 transactions (or preload via a bench `force`) → txn_count returns to 0x0000.
